// File: rtl/pll_rst_seq.sv
`timescale 1ns/1ps
// pll_rst_seq
// -----------
// Reset sequencer that sits directly behind the PLL. It synchronises the
// asynchronous PLL lock flag, waits until lock has been stable for a
// qualified interval, holds the system reset for a further fixed interval
// and then releases the design-wide active-low reset. Losing lock while
// running re-asserts the reset at once. If lock is never reached within a
// timeout window, the PLL itself is pulsed into reset and qualification
// starts over.
//
// Ports:
//   clk            in   system clock (PLL output)
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock flag, asynchronous to clk
//   sys_rst_n      out  registered system reset, active-low, high only in RUN
//   pll_rst        out  registered PLL reset request, active-high
//   lock_timeout   out  sticky: a lock timeout occurred since the last RUN entry
//   lock_loss_cnt  out  saturating count of lock losses seen while in RUN
//   state_o        out  current FSM state (debug)
//
// Parameter constraints: STABLE_CYCLES >= 1, RST_HOLD_CYCLES >= 1,
// LOCK_TIMEOUT >= 2, PLL_RST_CYCLES >= 1, CNT_W >= 1.

module pll_rst_seq #(
    parameter int STABLE_CYCLES   = 1024,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int PLL_RST_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             sys_rst_n,
    output logic             pll_rst,
    output logic             lock_timeout,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state_o
);

    // Phase counter serves STABLE, HOLD and PLL_RST; size it for the
    // largest of the three terminal values.
    localparam int PH_MAX_A = (STABLE_CYCLES > RST_HOLD_CYCLES) ? STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int PH_MAX   = (PH_MAX_A > PLL_RST_CYCLES) ? PH_MAX_A : PLL_RST_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX) + 1;
    localparam int TO_W     = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [PH_W-1:0]  STABLE_LAST  = PH_W'(STABLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST    = PH_W'(RST_HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  PLL_RST_LAST = PH_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST      = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              timeout_hit;
    logic              lock_timeout_d;
    logic [CNT_W-1:0]  loss_d;
    logic              sync_q;
    logic              lock_s;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous lock flag. Only lock_s
    // is allowed to reach the FSM; the first flop may go metastable.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; with blocking '=' here lock_s would pick
    // up the new sync_q in the same edge and the synchroniser would
    // collapse to a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lock_s <= sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and output logic
    // ------------------------------------------------------------------
    // NOTE: every signal written in this block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        tcnt_d         = tcnt_q + 1'b1;
        lock_timeout_d = lock_timeout;
        loss_d         = lock_loss_cnt;
        timeout_hit    = (tcnt_q == TO_LAST);

        unique case (state_q)
            WAIT_LOCK: begin
                // Timeout outranks a lock arriving on the same cycle.
                if (timeout_hit)  state_d = PLL_RST;
                else if (lock_s)  state_d = STABLE;
            end
            STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout_hit)                 state_d = PLL_RST;
                else if (!lock_s)                state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)   state_d = HOLD;
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout_hit)                 state_d = PLL_RST;
                else if (!lock_s)                state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST)     state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (lock_loss_cnt != LOSS_MAX) loss_d = lock_loss_cnt + 1'b1;
                end
            end
            PLL_RST: begin
                // Lock is deliberately ignored while the PLL is held in reset.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Each phase starts counting from zero.
        if (state_d != state_q) cnt_d = '0;

        // The timeout window only spans the qualification phases; a drop
        // from STABLE/HOLD back to WAIT_LOCK keeps the window running.
        if (state_q == RUN || state_q == PLL_RST ||
            state_d == RUN || state_d == PLL_RST) begin
            tcnt_d = '0;
        end

        if (state_d == PLL_RST)  lock_timeout_d = 1'b1;
        else if (state_d == RUN) lock_timeout_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            sys_rst_n     <= 1'b0;
            pll_rst       <= 1'b0;
            lock_timeout  <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            // Outputs are registered from the next state so they change on
            // the same edge as the state itself, with no combinational glitch.
            sys_rst_n     <= (state_d == RUN);
            pll_rst       <= (state_d == PLL_RST);
            lock_timeout  <= lock_timeout_d;
            lock_loss_cnt <= loss_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
`timescale 1ns/1ps
// Directed bench for pll_rst_seq with STABLE=4, HOLD=2, LOCK_TIMEOUT=20,
// PLL_RST=3, CNT_W=2. Edge 0 is the last rising edge with rst_n low;
// rst_n is released 1 ns after it. Outputs are sampled 1 ns after each edge.

module tb_pll_rst_seq;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             pll_locked;
    logic             sys_rst_n;
    logic             pll_rst;
    logic             lock_timeout;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [2:0]       state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int e     = 0;   // edge index relative to the last reset release

    pll_rst_seq #(
        .STABLE_CYCLES  (4),
        .RST_HOLD_CYCLES(2),
        .LOCK_TIMEOUT   (20),
        .PLL_RST_CYCLES (3),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sys_rst_n    (sys_rst_n),
        .pll_rst      (pll_rst),
        .lock_timeout (lock_timeout),
        .lock_loss_cnt(lock_loss_cnt),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, e, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    // Holds reset across a few edges, checks the reset state, then releases
    // rst_n just after edge 0.
    task automatic reset_dut();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",     state_o,       0);
        check("rst_sys_rst_n", sys_rst_n,     0);
        check("rst_pll_rst",   pll_rst,       0);
        check("rst_timeout",   lock_timeout,  0);
        check("rst_loss_cnt",  lock_loss_cnt, 0);
        rst_n = 1'b1;
        e     = 0;
    endtask

    // From RUN: drop lock just after edge n, expect reset at n+3, re-lock
    // just after n+3 and expect RUN 9 edges later.
    task automatic lose_and_relock(input int exp_cnt);
        pll_locked = 1'b0;
        tick(); tick();
        check("loss_still_run", sys_rst_n, 1);
        tick();
        check("loss_sys_rst_n", sys_rst_n, 0);
        check("loss_state",     state_o,   0);
        check("loss_cnt",       lock_loss_cnt, exp_cnt);
        pll_locked = 1'b1;
        repeat (8) tick();
        check("relock_hold_sys", sys_rst_n, 0);
        check("relock_hold_st",  state_o,   2);
        tick();
        check("relock_run_sys",  sys_rst_n, 1);
        check("relock_run_st",   state_o,   3);
    endtask

    function automatic int nom_state(input int k);
        if (k < 3)      return 0;
        else if (k < 7) return 1;
        else if (k < 9) return 2;
        else            return 3;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;

        // Nominal lock: STABLE at 3, HOLD at 7, RUN at 9.
        reset_dut();
        pll_locked = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("nom_state",     state_o,   nom_state(k));
            check("nom_sys_rst_n", sys_rst_n, (k >= 9) ? 1 : 0);
        end
        check("nom_pll_rst", pll_rst, 0);
        run_to(11);

        // Lock losses in RUN, saturating counter 1,2,3,3,3.
        for (int i = 1; i <= 5; i++) lose_and_relock((i > 3) ? 3 : i);

        // Async reset mid-RUN takes effect without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state",    state_o,       0);
        check("arst_sys_rst_n", sys_rst_n,    0);
        check("arst_loss_cnt", lock_loss_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e     = 0;
        run_to(8);
        check("arst_requal_hold", sys_rst_n, 0);
        check("arst_requal_st",   state_o,   2);
        run_to(9);
        check("arst_requal_run",  sys_rst_n, 1);

        // Two-cycle glitch during STABLE: back to WAIT_LOCK at 7, STABLE
        // again at 9, RUN at 15, no lock loss counted.
        reset_dut();
        pll_locked = 1'b1;
        run_to(4);
        pll_locked = 1'b0;
        run_to(6);
        check("gl_still_stable", state_o, 1);
        pll_locked = 1'b1;
        run_to(7);
        check("gl_wait",       state_o, 0);
        run_to(8);
        check("gl_wait2",      state_o, 0);
        run_to(9);
        check("gl_stable",     state_o, 1);
        run_to(14);
        check("gl_hold_sys",   sys_rst_n, 0);
        check("gl_hold_st",    state_o,   2);
        run_to(15);
        check("gl_run_sys",    sys_rst_n, 1);
        check("gl_run_st",     state_o,   3);
        check("gl_loss_cnt",   lock_loss_cnt, 0);

        // Timeout: pll_rst at 20..22, WAIT_LOCK at 23, again at 43..45,
        // then a lock reaching RUN clears lock_timeout.
        reset_dut();
        run_to(19);
        check("to_pre_pll_rst", pll_rst,      0);
        check("to_pre_flag",    lock_timeout, 0);
        check("to_pre_state",   state_o,      0);
        run_to(20);
        check("to_pll_rst",     pll_rst,      1);
        check("to_state",       state_o,      4);
        check("to_flag",        lock_timeout, 1);
        run_to(22);
        check("to_pll_rst_end", pll_rst,      1);
        run_to(23);
        check("to_release",     pll_rst,      0);
        check("to_back_wait",   state_o,      0);
        check("to_flag_sticky", lock_timeout, 1);
        run_to(42);
        check("to2_pre",        pll_rst,      0);
        run_to(43);
        check("to2_pll_rst",    pll_rst,      1);
        run_to(45);
        check("to2_pll_rst_end", pll_rst,     1);
        run_to(46);
        check("to2_release",    pll_rst,      0);
        check("to2_state",      state_o,      0);
        pll_locked = 1'b1;
        run_to(54);
        check("to_lock_hold_flag", lock_timeout, 1);
        check("to_lock_hold_sys",  sys_rst_n,    0);
        run_to(55);
        check("to_lock_run_sys",   sys_rst_n,    1);
        check("to_lock_run_flag",  lock_timeout, 0);
        check("to_lock_run_st",    state_o,      3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset sequencer placed directly downstream of the PLL.
- Consumes the PLL `locked` flag, which is asynchronous to `clk`.
- Generates the design-wide synchronous-deassert system reset `sys_rst_n` once lock has been stable for a qualified interval.
- Re-asserts the system reset on lock loss and issues PLL reset retries when lock never arrives.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before the reset hold phase. Must be ≥1.
- RST_HOLD_CYCLES, 16: cycles `sys_rst_n` stays low after lock qualification. Must be ≥1.
- LOCK_TIMEOUT, 65536: cycles without reaching RUN before a PLL reset pulse is issued. Must be ≥2.
- PLL_RST_CYCLES, 8: width of the `pll_rst` pulse in cycles. Must be ≥1.
- CNT_W, 8: width of `lock_loss_cnt`.

Ports:
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag, asynchronous to clk.
- sys_rst_n  out  1  system reset, active-low, registered.
- pll_rst  out  1  PLL reset request, active-high, registered.
- lock_timeout  out  1  sticky flag: at least one timeout has occurred since the last RUN entry.
- lock_loss_cnt  out  CNT_W  number of lock losses seen in RUN, saturating.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- **Reset.** rst_n low asynchronously forces the following; all counters clear; the sync flops clear.
  - state = WAIT_LOCK
  - sys_rst_n = 0
  - pll_rst = 0
  - lock_timeout = 0
  - lock_loss_cnt = 0
- **Synchronizer.** `pll_locked` passes through 2 flops to form `lock_s`. Only `lock_s` is used by the FSM.
- **State encoding.** WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3, PLL_RST=4.
- **Output registers.**
  - `sys_rst_n` is registered and equals (next_state==RUN); it is never high outside RUN.
  - `pll_rst` is registered and equals (next_state==PLL_RST).
- **Counters.**
  - `cnt` is the phase counter; it is cleared on every state change.
  - `tcnt` is the timeout counter. It increments in WAIT_LOCK, STABLE and HOLD, and is cleared in RUN and PLL_RST.
- **WAIT_LOCK.**
  - If tcnt==LOCK_TIMEOUT-1 → PLL_RST, and set lock_timeout. This check has priority over lock.
  - Else if lock_s=1 → STABLE.
- **STABLE.**
  - lock_s=0 → WAIT_LOCK. No lock_loss_cnt change; tcnt keeps counting.
  - Else if cnt==STABLE_CYCLES-1 → HOLD.
  - Else cnt++.
  - Timeout → PLL_RST, with the same priority as in WAIT_LOCK.
- **HOLD.**
  - lock_s=0 → WAIT_LOCK.
  - Else if cnt==RST_HOLD_CYCLES-1 → RUN.
  - Timeout → PLL_RST, with the same priority.
- **RUN.**
  - lock_s=0 → WAIT_LOCK. sys_rst_n goes low on that same edge; lock_loss_cnt increments, saturating at 2^CNT_W-1.
  - lock_timeout clears on entry to RUN.
- **PLL_RST.**
  - lock_s is ignored.
  - After PLL_RST_CYCLES cycles → WAIT_LOCK with tcnt=0.
- **Latency.** With pll_locked driven high just after edge 0 and held, sys_rst_n rises at edge 3+STABLE_CYCLES+RST_HOLD_CYCLES.
- **Lock loss in RUN.** Lock dropped just after edge n drives sys_rst_n low at edge n+3.
- **Glitches.** Any glitch on pll_locked shorter than 1 cycle may or may not be seen. If seen before RUN, it restarts qualification.
- **Counter widths.** Each counter is $clog2 of its terminal value plus 1 bit. Counters never wrap, because terminal compares cause a state exit.

Test Plan:
- **Nominal lock.** STABLE=4, HOLD=2. rst_n released, then pll_locked high just after edge 0 → sys_rst_n low through edge 8, high from edge 9; state_o goes 0→1 at edge 3, →2 at edge 7, →3 at edge 9.
- **Lock loss in RUN.** In RUN, drop pll_locked just after edge n → sys_rst_n=0 from edge n+3 and lock_loss_cnt 0→1. Re-lock → sys_rst_n rises 9 edges after the re-lock edge.
- **Glitch during STABLE.** pll_locked low for 2 cycles in mid-STABLE → return to WAIT_LOCK with cnt restarted; lock_loss_cnt stays 0; total latency extended accordingly.
- **Timeout.** LOCK_TIMEOUT=20, PLL_RST=3, pll_locked held low → pll_rst=1 for edges 20–22, lock_timeout=1 from edge 20, WAIT_LOCK at edge 23, repeat at edge 43. A later lock reaching RUN clears lock_timeout.
- **Saturation.** CNT_W=2, 5 RUN lock losses → lock_loss_cnt reads 1,2,3,3,3.
- **Async reset mid-RUN.** rst_n pulsed low between edges → sys_rst_n=0, lock_loss_cnt=0 and state_o=0 immediately, without waiting for a clock. Full qualification is required after rst_n release.
